lfsr_fibonacci_checker: RTL and testbench
=========================================

Name: lfsr_fibonacci_checker

Overview:
Receive-side PRBS checker paired with the Fibonacci LFSR generator. It accepts the serial bitstream the generator produces and self-synchronises a local LFSR to it. It then runs free and counts every bit that differs from the prediction. It sits at the far end of a serial link or loopback path and reports lock status and the bit-error count to the test controller.

Parameters:
W, 8, LFSR width in bits (W >= 3)
CNT_W, 16, width of the saturating error counter
LOCK_N, 16, consecutive matches in VERIFY required to declare lock
LOSS_N, 8, consecutive mismatches in LOCKED that drop lock

Ports:
CLK_I  in  1  clock
RST_N_I  in  1  reset, asynchronous, active-low
LOAD_I  in  1  latch POLY_I and restart the search (enter HUNT)
POLY_I  in  W  tap mask; same encoding as the generator
EN_I  in  1  BIT_I valid this cycle
BIT_I  in  1  received serial bit
CLR_I  in  1  synchronous clear of ERR_CNT_O and the loss counter; lock is kept
LOCK_O  out  1  checker locked (registered)
ERR_O  out  1  one-cycle pulse: mismatch detected while LOCKED (registered)
ERR_CNT_O  out  CNT_W  saturating mismatch count while LOCKED
STATE_O  out  2  FSM state: 0 HUNT, 1 VERIFY, 2 LOCKED

Behaviour:
- LFSR convention (identical to the generator):
  - Predicted bit p = ^(state & poly).
  - Shift step: state <= {state[W-2:0], in}.
  - The generator emits its feedback bit as the serial output.
- Reset values:
  - state, poly, all counters and every output are 0.
  - FSM is in HUNT.
- Cycles with EN_I=0: nothing advances. ERR_O is 0.
- LOAD_I: poly <= POLY_I; FSM -> HUNT; fill and match counters -> 0; LOCK_O -> 0.
  - ERR_CNT_O is unchanged.
  - LOAD_I has priority over EN_I and over CLR_I's FSM effects in the same cycle. A CLR_I in the same cycle still clears the counters.
- HUNT:
  - On each EN_I: state <= {state[W-2:0], BIT_I}; fill counter +1.
  - After W valid bits: -> VERIFY with match counter 0.
- VERIFY (self-synchronising):
  - On each EN_I: compare BIT_I with p, then shift in BIT_I (the received bit, not p).
  - Match: match counter +1. Reaching LOCK_N -> LOCKED; LOCK_O=1 from the next cycle.
  - Mismatch: -> HUNT with fill counter 0. The state contents are kept.
  - No errors are counted in VERIFY.
- LOCKED (free-running):
  - On each EN_I: shift in p, not BIT_I, so a single line error costs exactly one count.
  - Mismatch:
    - ERR_O=1 in the next cycle.
    - ERR_CNT_O +1, saturating at 2^CNT_W-1 with no wrap.
    - Loss counter +1.
  - Match: loss counter -> 0.
  - Loss counter reaching LOSS_N: -> HUNT; LOCK_O -> 0 in the next cycle. That final mismatch is still counted.
- CLR_I and a mismatch in the same cycle: clear wins and ERR_CNT_O=0. ERR_O still pulses.
- Latency: BIT_I sampled at edge k -> ERR_O and ERR_CNT_O update visible after edge k.
- All-zero state:
  - If the state is all zeros in VERIFY or LOCKED, p is 0 forever and a 0-stream would "lock".
  - The checker treats a state of all zeros on entry to VERIFY as a mismatch and returns to HUNT.
- Changing POLY_I without LOAD_I has no effect.
- Reset mid-stream returns everything to reset values immediately (asynchronous).

Decomposition:
- Package lfsr_pkg:
  - State enum (HUNT, VERIFY, LOCKED).
  - A function lfsr_fb(state, poly) returning ^(state & poly), shared with the generator so both ends use one definition.
- Natural sub-module: lfsr_sat_counter (parameterised width, inc, clr, saturate), used for ERR_CNT_O.
- The FSM, shift register and loss/match counters stay in the top module.

Test Plan:
1. Reset, LOAD_I with POLY_I=8'hB8, then feed 300 bits from the generator (seed 8'h01, poly 8'hB8):
   - STATE_O goes 0 -> 1 after 8 bits and 1 -> 2 after 8+16=24 bits.
   - LOCK_O=1, ERR_CNT_O=0 at end.
2. Locked on the 8'hB8 stream, invert one bit at bit index 100:
   - Exactly one ERR_O pulse, the cycle after that bit.
   - ERR_CNT_O=1; lock held.
3. Locked, then switch the source to all-ones:
   - LOCK_O drops after 8 consecutive mismatches; ERR_CNT_O equals the mismatches counted, including the 8th.
   - Checker re-enters HUNT, then returns to HUNT again via the all-zero/mismatch rules and never locks on the wrong polynomial.
4. Locked, assert CLR_I together with an injected error:
   - ERR_CNT_O=0 and ERR_O pulses.
   - The next injected error gives ERR_CNT_O=1.
5. CNT_W=4, locked, inject 20 isolated errors:
   - ERR_CNT_O saturates at 15.
6. An all-zero stream from reset never asserts LOCK_O. Assert RST_N_I low mid-LOCKED: all outputs are 0 immediately.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions used by both the PRBS generator and checker.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    // Callers zero-extend narrower registers; unused upper bits contribute nothing.
    function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] state,
                                     input logic [LFSR_MAX_W-1:0] poly);
        return ^(state & poly);
    endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/lfsr_fibonacci_checker.sv
// Receive-side PRBS checker: self-synchronises a local Fibonacci LFSR to the
// incoming stream, then free-runs and counts mismatches while locked.
module lfsr_fibonacci_checker
    import lfsr_pkg::*;
#(
    parameter int W      = 8,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 16,
    parameter int LOSS_N = 8
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    input  logic             LOAD_I,
    input  logic [W-1:0]     POLY_I,
    input  logic             EN_I,
    input  logic             BIT_I,
    input  logic             CLR_I,
    output logic             LOCK_O,
    output logic             ERR_O,
    output logic [CNT_W-1:0] ERR_CNT_O,
    output logic [1:0]       STATE_O
);

    localparam int FILL_W  = $clog2(W + 1);
    localparam int MATCH_W = $clog2(LOCK_N + 1);
    localparam int LOSS_W  = $clog2(LOSS_N + 1);

    lfsr_state_e         fsm_q;
    logic [W-1:0]        state_q;
    logic [W-1:0]        poly_q;
    logic [FILL_W-1:0]   fill_q;
    logic [MATCH_W-1:0]  match_q;
    logic [LOSS_W-1:0]   loss_q;
    logic                lock_q;
    logic                err_q;
    logic                pred;
    logic                miss;
    logic                cnt_inc;

    assign pred    = lfsr_fb(LFSR_MAX_W'(state_q), LFSR_MAX_W'(poly_q));
    assign miss    = (pred != BIT_I);
    assign cnt_inc = EN_I && !LOAD_I && (fsm_q == LOCKED) && miss;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            fsm_q   <= HUNT;
            state_q <= '0;
            poly_q  <= '0;
            fill_q  <= '0;
            match_q <= '0;
            loss_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (LOAD_I) begin
                poly_q  <= POLY_I;
                fsm_q   <= HUNT;
                fill_q  <= '0;
                match_q <= '0;
                loss_q  <= '0;
                lock_q  <= 1'b0;
            end else begin
                if (EN_I) begin
                    case (fsm_q)
                        HUNT: begin
                            state_q <= {state_q[W-2:0], BIT_I};
                            if (fill_q == FILL_W'(W - 1)) begin
                                fsm_q   <= VERIFY;
                                fill_q  <= '0;
                                match_q <= '0;
                            end else begin
                                fill_q <= fill_q + 1'b1;
                            end
                        end
                        VERIFY: begin
                            state_q <= {state_q[W-2:0], BIT_I};
                            // An all-zero register predicts 0 forever, so it must never verify.
                            if (miss || (state_q == '0)) begin
                                fsm_q  <= HUNT;
                                fill_q <= '0;
                            end else if (match_q == MATCH_W'(LOCK_N - 1)) begin
                                fsm_q  <= LOCKED;
                                lock_q <= 1'b1;
                                loss_q <= '0;
                            end else begin
                                match_q <= match_q + 1'b1;
                            end
                        end
                        LOCKED: begin
                            // Free-run on the prediction so one line error costs one count.
                            state_q <= {state_q[W-2:0], pred};
                            if (miss) begin
                                err_q <= 1'b1;
                                if (!CLR_I && (loss_q == LOSS_W'(LOSS_N - 1))) begin
                                    fsm_q  <= HUNT;
                                    lock_q <= 1'b0;
                                    fill_q <= '0;
                                    loss_q <= '0;
                                end else begin
                                    loss_q <= loss_q + 1'b1;
                                end
                            end else begin
                                loss_q <= '0;
                            end
                        end
                        default: fsm_q <= HUNT;
                    endcase
                end
                if (CLR_I)
                    loss_q <= '0;
            end
        end
    end

    lfsr_sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .CLK_I   (CLK_I),
        .RST_N_I (RST_N_I),
        .inc     (cnt_inc),
        .clr     (CLR_I),
        .count   (ERR_CNT_O)
    );

    assign LOCK_O  = lock_q;
    assign ERR_O   = err_q;
    assign STATE_O = fsm_q;

endmodule

// File: tb/tb_lfsr_fibonacci_checker.sv
// Scoreboard bench: driver pushes expected outputs per valid bit, monitor pops and compares.
module tb_lfsr_fibonacci_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  poly = 8'h00;
    logic        en = 1'b0;
    logic        bit_i = 1'b0;
    logic        clr = 1'b0;
    logic        lock_o, err_o, lock4, err4;
    logic [15:0] cnt_o;
    logic [3:0]  cnt4;
    logic [1:0]  st_o, st4;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       lk;
        logic       er;
        logic [15:0] cnt;
        logic [3:0] cnt4;
    } exp_t;

    exp_t sb[$];
    bit   chk_pend = 1'b0;
    bit   force_chk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] g;

    always #5 clk = ~clk;

    lfsr_fibonacci_checker #(.W(8), .CNT_W(16), .LOCK_N(16), .LOSS_N(8)) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .LOAD_I(load), .POLY_I(poly), .EN_I(en),
        .BIT_I(bit_i), .CLR_I(clr), .LOCK_O(lock_o), .ERR_O(err_o),
        .ERR_CNT_O(cnt_o), .STATE_O(st_o)
    );

    lfsr_fibonacci_checker #(.W(8), .CNT_W(4), .LOCK_N(16), .LOSS_N(8)) dut4 (
        .CLK_I(clk), .RST_N_I(rst_n), .LOAD_I(load), .POLY_I(poly), .EN_I(en),
        .BIT_I(bit_i), .CLR_I(clr), .LOCK_O(lock4), .ERR_O(err4),
        .ERR_CNT_O(cnt4), .STATE_O(st4)
    );

    always @(posedge clk) chk_pend <= en && rst_n;

    always @(negedge clk or posedge force_chk) begin
        if (chk_pend || force_chk) begin
            exp_t e;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: output seen with no expected entry");
            end else begin
                e = sb.pop_front();
                if (st_o !== e.st || lock_o !== e.lk || err_o !== e.er ||
                    cnt_o !== e.cnt || cnt4 !== e.cnt4) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d lock=%0b err=%0b cnt=%0d cnt4=%0d want st=%0d lock=%0b err=%0b cnt=%0d cnt4=%0d",
                             e.tag, st_o, lock_o, err_o, cnt_o, cnt4,
                             e.st, e.lk, e.er, e.cnt, e.cnt4);
                end
            end
        end
    end

    task automatic push(input string tag, input logic [1:0] st, input logic lk,
                        input logic er, input int cnt);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.lk   = lk;
        e.er   = er;
        e.cnt  = 16'(cnt);
        e.cnt4 = (cnt > 15) ? 4'd15 : 4'(cnt);
        sb.push_back(e);
    endtask

    task automatic send(input string tag, input logic b, input logic c,
                        input logic [1:0] st, input logic lk, input logic er, input int cnt);
        @(negedge clk);
        en = 1'b1; bit_i = b; clr = c;
        push(tag, st, lk, er, cnt);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; bit_i = 1'b0;
    endtask

    // Assert reset between clock edges and check outputs are already cleared.
    task automatic do_reset(input string tag);
        @(negedge clk);
        en = 1'b0; load = 1'b0; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 push(tag, 2'd0, 1'b0, 1'b0, 0);
        force_chk = 1'b1;
        #1 force_chk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [7:0] p);
        @(negedge clk);
        en = 1'b0; load = 1'b1; poly = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic gen(output logic b);
        b = ^(g & 8'hB8);
        g = {g[6:0], b};
    endtask

    function automatic logic [1:0] sync_st(input int i);
        return (i < 7) ? 2'd0 : (i < 23) ? 2'd1 : 2'd2;
    endfunction

    initial begin
        logic b;
        int   k;

        do_reset("reset_state");

        // Clean stream: HUNT for 8 bits, VERIFY for 16, then locked with no errors.
        do_load(8'hB8);
        g = 8'h01;
        for (int i = 0; i < 300; i++) begin
            gen(b);
            send("clean_lock", b, 1'b0, sync_st(i), i >= 23, 1'b0, 0);
        end
        idle();

        // Single line error at bit 100: one pulse, one count, lock held.
        do_reset("reset_t2");
        do_load(8'hB8);
        g = 8'h01;
        for (int i = 0; i < 150; i++) begin
            gen(b);
            if (i == 100) b = ~b;
            send("single_err", b, 1'b0, sync_st(i), i >= 23, i == 100, (i >= 100) ? 1 : 0);
        end

        // Inverted source: 8 consecutive mismatches drop lock, last one still counted.
        for (int i = 0; i < 8; i++) begin
            gen(b);
            send("loss_of_lock", ~b, 1'b0, (i == 7) ? 2'd0 : 2'd2, i != 7, 1'b1, 2 + i);
        end
        // All-ones source against 8'hB8 never verifies: HUNT 8, VERIFY 1, repeat.
        for (int j = 0; j < 36; j++)
            send("ones_rehunt", 1'b1, 1'b0, (j % 9 == 7) ? 2'd1 : 2'd0, 1'b0, 1'b0, 9);

        // Reload without reset keeps the count; clear coinciding with an error wins.
        do_load(8'hB8);
        g = 8'h01;
        for (int i = 0; i < 60; i++) begin
            gen(b);
            if (i == 45 || i == 55) b = ~b;
            send("clr_vs_err", b, i == 45, sync_st(i), i >= 23, i == 45 || i == 55,
                 (i < 45) ? 9 : (i < 55) ? 0 : 1);
        end
        idle();

        // Twenty isolated errors: 16-bit count reaches 20, 4-bit count sticks at 15.
        do_reset("reset_t5");
        do_load(8'hB8);
        g = 8'h01;
        for (int i = 0; i < 130; i++) begin
            gen(b);
            k = 0;
            if (i >= 30) k = ((i - 30) / 5 + 1 > 20) ? 20 : (i - 30) / 5 + 1;
            if (i >= 30 && i <= 125 && (i - 30) % 5 == 0) b = ~b;
            send("saturate", b, 1'b0, sync_st(i), i >= 23,
                 i >= 30 && i <= 125 && (i - 30) % 5 == 0, k);
        end
        idle();

        // All-zero stream from reset: enters VERIFY, rejected, never locks.
        do_reset("reset_t6");
        do_load(8'hB8);
        for (int j = 0; j < 40; j++)
            send("zeros_no_lock", 1'b0, 1'b0, (j % 9 == 7) ? 2'd1 : 2'd0, 1'b0, 1'b0, 0);

        // Lock, take one error, then reset asynchronously while ERR_O is high.
        do_load(8'hB8);
        g = 8'h01;
        for (int i = 0; i < 31; i++) begin
            gen(b);
            if (i == 30) b = ~b;
            send("pre_async_rst", b, 1'b0, sync_st(i), i >= 23, i == 30, (i == 30) ? 1 : 0);
        end
        do_reset("async_reset_locked");

        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
